bank_timing_tracker: RTL and testbench

Multi-bank DRAM timing tracker: the parametrised successor to the single-bank command timing controller. It enforces per-bank and rank-level JEDEC spacing rules:

- Per bank: tRCD, tRAS, tRP, write recovery.
- Rank level: tRRD, tFAW, tCCD, tWTR, tRFC.

It sits between the command scheduler and the PHY. Each cycle it exports per-bank "command legal" vectors, and it tracks each command the scheduler issues. It also generates data-window strobes and a refresh request with postponement credit.

---
 rtl/bank_timing_tracker.sv | 227 ++++++++++++++++++++++
 tb/tb_bank_timing_tracker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_timing_tracker.sv
// Multi-bank DRAM command timing tracker: per-bank and rank-level spacing counters,
// per-bank legality vectors, data-window strobes and refresh-owed bookkeeping.
module bank_timing_tracker #(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned tRCD         = 4,
  parameter int unsigned tRAS         = 10,
  parameter int unsigned tRP          = 4,
  parameter int unsigned tRL          = 5,
  parameter int unsigned tWL          = 4,
  parameter int unsigned tBURST       = 4,
  parameter int unsigned tWR          = 5,
  parameter int unsigned tWTR         = 3,
  parameter int unsigned tRRD         = 2,
  parameter int unsigned tFAW         = 16,
  parameter int unsigned tCCD         = 4,
  parameter int unsigned tRFC         = 40,
  parameter int unsigned tREFI        = 780,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic                         clk,
  input  logic                         nRST,
  input  logic                         cmd_valid,
  input  logic [2:0]                   cmd_type,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic [NUM_BANKS-1:0]         act_ok,
  output logic [NUM_BANKS-1:0]         rd_ok,
  output logic [NUM_BANKS-1:0]         wr_ok,
  output logic [NUM_BANKS-1:0]         pre_ok,
  output logic                         ref_ok,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         rd_en,
  output logic                         wr_en,
  output logic                         rf_req,
  output logic                         rf_urgent,
  output logic                         illegal_cmd
);

  localparam int unsigned BANK_W    = $clog2(NUM_BANKS);
  localparam int unsigned FAW_SLOTS = 4;
  localparam int unsigned RD_L      = tRL + tBURST - 1;
  localparam int unsigned WR_L      = tWL + tBURST - 1;
  localparam int unsigned REFI_W    = $clog2(tREFI + 1);
  localparam int unsigned OWED_W    = $clog2(MAX_POSTPONE + 2);

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(tRCD - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(tRAS - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(tRP - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(tWL + tBURST + tWR - 1);
  localparam logic [CNT_W-1:0] WTR_LD = CNT_W'(tWL + tBURST + tWTR - 1);
  localparam logic [CNT_W-1:0] RRD_LD = CNT_W'(tRRD - 1);
  localparam logic [CNT_W-1:0] CCD_LD = CNT_W'(tCCD - 1);
  localparam logic [CNT_W-1:0] FAW_LD = CNT_W'(tFAW - 1);
  localparam logic [CNT_W-1:0] RFC_LD = CNT_W'(tRFC - 1);

  // Pipeline bit j is set j+1 cycles after the command; the mask selects the burst window.
  localparam logic [RD_L-1:0] RD_MASK = {RD_L{1'b1}} << (tRL - 1);
  localparam logic [WR_L-1:0] WR_MASK = {WR_L{1'b1}} << (tWL - 1);

  if ((64'(tWL) + 64'(tBURST) + 64'(tWR)) >= (64'd1 << CNT_W) ||
      (64'(tWL) + 64'(tBURST) + 64'(tWTR)) >= (64'd1 << CNT_W)) begin : g_width_chk
    $error("bank_timing_tracker: recovery sums do not fit in CNT_W");
  end

  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [CNT_W-1:0]     rcd_q [NUM_BANKS];
  logic [CNT_W-1:0]     rcd_d [NUM_BANKS];
  logic [CNT_W-1:0]     ras_q [NUM_BANKS];
  logic [CNT_W-1:0]     ras_d [NUM_BANKS];
  logic [CNT_W-1:0]     rp_q  [NUM_BANKS];
  logic [CNT_W-1:0]     rp_d  [NUM_BANKS];
  logic [CNT_W-1:0]     wrr_q [NUM_BANKS];
  logic [CNT_W-1:0]     wrr_d [NUM_BANKS];
  logic [CNT_W-1:0]     faw_q [FAW_SLOTS];
  logic [CNT_W-1:0]     faw_d [FAW_SLOTS];
  logic [CNT_W-1:0]     rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rfc_q, rfc_d;
  logic [RD_L-1:0]      rd_pipe_q, rd_pipe_d;
  logic [WR_L-1:0]      wr_pipe_q, wr_pipe_d;
  logic [REFI_W-1:0]    refi_q, refi_d;
  logic [OWED_W-1:0]    owed_q, owed_d;
  logic                 illegal_q, illegal_d;

  logic                 faw_free, rp_idle, rank_act_ok, col_ok;
  logic [NUM_BANKS-1:0] bank_sel;
  logic                 is_act, is_rd, is_wr, is_pre, is_ref, ok_sel;
  logic                 act_app, rd_app, wr_app, pre_app, ref_app, refi_wrap, faw_placed;

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  always_comb begin
    faw_free = 1'b0;
    for (int unsigned i = 0; i < FAW_SLOTS; i++)
      if (faw_q[i] == '0) faw_free = 1'b1;
    rp_idle = 1'b1;
    for (int unsigned b = 0; b < NUM_BANKS; b++)
      if (rp_q[b] != '0) rp_idle = 1'b0;
    rank_act_ok = (rrd_q == '0) && faw_free && (rfc_q == '0);
    col_ok      = (ccd_q == '0);
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      act_ok[b] = !open_q[b] && (rp_q[b] == '0) && rank_act_ok;
      rd_ok[b]  = open_q[b] && (rcd_q[b] == '0) && col_ok && (wtr_q == '0);
      wr_ok[b]  = open_q[b] && (rcd_q[b] == '0) && col_ok;
      pre_ok[b] = open_q[b] && (ras_q[b] == '0) && (wrr_q[b] == '0);
    end
    ref_ok = (open_q == '0) && rp_idle && (rfc_q == '0);
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++)
      bank_sel[b] = (cmd_bank == BANK_W'(b));
    is_act = cmd_valid && (cmd_type == CMD_ACT);
    is_rd  = cmd_valid && (cmd_type == CMD_RD);
    is_wr  = cmd_valid && (cmd_type == CMD_WR);
    is_pre = cmd_valid && (cmd_type == CMD_PRE);
    is_ref = cmd_valid && (cmd_type == CMD_REF);
    ok_sel = 1'b0;
    if (is_act) ok_sel = |(act_ok & bank_sel);
    if (is_rd)  ok_sel = |(rd_ok & bank_sel);
    if (is_wr)  ok_sel = |(wr_ok & bank_sel);
    if (is_pre) ok_sel = |(pre_ok & bank_sel);
    if (is_ref) ok_sel = ref_ok;
    act_app   = is_act && ok_sel;
    rd_app    = is_rd && ok_sel;
    wr_app    = is_wr && ok_sel;
    pre_app   = is_pre && ok_sel;
    ref_app   = is_ref && ok_sel;
    illegal_d = (is_act || is_rd || is_wr || is_pre || is_ref) && !ok_sel;
  end

  always_comb begin
    open_d = open_q;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      rcd_d[b] = dec(rcd_q[b]);
      ras_d[b] = dec(ras_q[b]);
      rp_d[b]  = dec(rp_q[b]);
      wrr_d[b] = dec(wrr_q[b]);
      if (bank_sel[b] && act_app) begin
        rcd_d[b]  = RCD_LD;
        ras_d[b]  = RAS_LD;
        open_d[b] = 1'b1;
      end
      if (bank_sel[b] && pre_app) begin
        rp_d[b]   = RP_LD;
        open_d[b] = 1'b0;
      end
      if (bank_sel[b] && wr_app) wrr_d[b] = WR_LD;
    end
    rrd_d = act_app ? RRD_LD : dec(rrd_q);
    ccd_d = (rd_app || wr_app) ? CCD_LD : dec(ccd_q);
    wtr_d = wr_app ? WTR_LD : dec(wtr_q);
    rfc_d = ref_app ? RFC_LD : dec(rfc_q);
    faw_placed = 1'b0;
    for (int unsigned i = 0; i < FAW_SLOTS; i++) begin
      faw_d[i] = dec(faw_q[i]);
      if (act_app && !faw_placed && (faw_q[i] == '0)) begin
        faw_d[i]   = FAW_LD;
        faw_placed = 1'b1;
      end
    end
    rd_pipe_d = (rd_pipe_q << 1) | RD_L'(rd_app);
    wr_pipe_d = (wr_pipe_q << 1) | WR_L'(wr_app);
    refi_wrap = (refi_q == REFI_W'(tREFI - 1));
    refi_d    = refi_wrap ? '0 : refi_q + REFI_W'(1);
    // A wrap and an applied REF cancel; otherwise saturate up or floor at zero.
    owed_d = owed_q;
    if (refi_wrap && !ref_app && (owed_q != OWED_W'(MAX_POSTPONE + 1)))
      owed_d = owed_q + OWED_W'(1);
    else if (ref_app && !refi_wrap && (owed_q != '0))
      owed_d = owed_q - OWED_W'(1);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      open_q <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= '0;
        ras_q[b] <= '0;
        rp_q[b]  <= '0;
        wrr_q[b] <= '0;
      end
      for (int unsigned i = 0; i < FAW_SLOTS; i++) faw_q[i] <= '0;
      rrd_q     <= '0;
      ccd_q     <= '0;
      wtr_q     <= '0;
      rfc_q     <= '0;
      rd_pipe_q <= '0;
      wr_pipe_q <= '0;
      refi_q    <= '0;
      owed_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      open_q <= open_d;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= rcd_d[b];
        ras_q[b] <= ras_d[b];
        rp_q[b]  <= rp_d[b];
        wrr_q[b] <= wrr_d[b];
      end
      for (int unsigned i = 0; i < FAW_SLOTS; i++) faw_q[i] <= faw_d[i];
      rrd_q     <= rrd_d;
      ccd_q     <= ccd_d;
      wtr_q     <= wtr_d;
      rfc_q     <= rfc_d;
      rd_pipe_q <= rd_pipe_d;
      wr_pipe_q <= wr_pipe_d;
      refi_q    <= refi_d;
      owed_q    <= owed_d;
      illegal_q <= illegal_d;
    end
  end

  assign bank_open   = open_q;
  assign rd_en       = |(rd_pipe_q & RD_MASK);
  assign wr_en       = |(wr_pipe_q & WR_MASK);
  assign rf_req      = (owed_q != '0);
  assign rf_urgent   = (owed_q >= OWED_W'(MAX_POSTPONE));
  assign illegal_cmd = illegal_q;

endmodule

// File: tb/tb_bank_timing_tracker.sv
// Bench for bank_timing_tracker: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized command traffic.
module tb_bank_timing_tracker;
  localparam int NB = 4;
  localparam int T_RCD = 4, T_RAS = 10, T_RP = 4, T_RL = 5, T_WL = 4, T_BURST = 4;
  localparam int T_WR = 5, T_WTR = 3, T_RRD = 2, T_FAW = 16, T_CCD = 4, T_RFC = 40;
  localparam int T_REFI = 780, MAXP = 8;
  localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_REF = 5;
  localparam longint NEG = -100000;

  logic          clk = 1'b0, nRST = 1'b0, cmd_valid = 1'b0;
  logic [2:0]    cmd_type = 3'd0;
  logic [1:0]    cmd_bank = 2'd0;
  logic [NB-1:0] act_ok, rd_ok, wr_ok, pre_ok, bank_open;
  logic          ref_ok, rd_en, wr_en, rf_req, rf_urgent, illegal_cmd;

  bank_timing_tracker #(
    .NUM_BANKS(NB), .CNT_W(10), .tRCD(T_RCD), .tRAS(T_RAS), .tRP(T_RP), .tRL(T_RL),
    .tWL(T_WL), .tBURST(T_BURST), .tWR(T_WR), .tWTR(T_WTR), .tRRD(T_RRD), .tFAW(T_FAW),
    .tCCD(T_CCD), .tRFC(T_RFC), .tREFI(T_REFI), .MAX_POSTPONE(MAXP)
  ) dut (
    .clk(clk), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
    .act_ok(act_ok), .rd_ok(rd_ok), .wr_ok(wr_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
    .bank_open(bank_open), .rd_en(rd_en), .wr_en(wr_en), .rf_req(rf_req),
    .rf_urgent(rf_urgent), .illegal_cmd(illegal_cmd)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, a, e, $time);
    end
  endtask

  // Reference model: cycle-stamped history of applied commands.
  longint cyc;
  bit     m_open [NB];
  longint t_act [NB], t_pre [NB], t_wr [NB];
  longint t_act_any, t_col, t_wr_any, t_ref;
  longint act_q[$], rd_q[$], wr_q[$];
  int     owed;
  bit     m_ill;

  function automatic void m_reset();
    cyc = 0;
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 0; t_act[b] = NEG; t_pre[b] = NEG; t_wr[b] = NEG;
    end
    t_act_any = NEG; t_col = NEG; t_wr_any = NEG; t_ref = NEG;
    act_q.delete(); rd_q.delete(); wr_q.delete();
    owed = 0; m_ill = 0;
  endfunction

  function automatic int faw_count();
    int n = 0;
    foreach (act_q[i]) if (cyc - act_q[i] < T_FAW) n++;
    return n;
  endfunction

  function automatic bit m_act_ok(input int b);
    return !m_open[b] && (cyc - t_pre[b] >= T_RP) && (cyc - t_act_any >= T_RRD)
        && (faw_count() < 4) && (cyc - t_ref >= T_RFC);
  endfunction
  function automatic bit m_wr_ok(input int b);
    return m_open[b] && (cyc - t_act[b] >= T_RCD) && (cyc - t_col >= T_CCD);
  endfunction
  function automatic bit m_rd_ok(input int b);
    return m_wr_ok(b) && (cyc - t_wr_any >= T_WL + T_BURST + T_WTR);
  endfunction
  function automatic bit m_pre_ok(input int b);
    return m_open[b] && (cyc - t_act[b] >= T_RAS) && (cyc - t_wr[b] >= T_WL + T_BURST + T_WR);
  endfunction
  function automatic bit m_ref_ok();
    bit ok = (cyc - t_ref >= T_RFC);
    for (int b = 0; b < NB; b++) if (m_open[b] || (cyc - t_pre[b] < T_RP)) ok = 0;
    return ok;
  endfunction
  function automatic bit m_legal(input int t, input int b);
    case (t)
      C_ACT:   return m_act_ok(b);
      C_RD:    return m_rd_ok(b);
      C_WR:    return m_wr_ok(b);
      C_PRE:   return m_pre_ok(b);
      C_REF:   return m_ref_ok();
      default: return 0;
    endcase
  endfunction
  function automatic bit in_window(input longint q[$], input int lat);
    foreach (q[i]) if (cyc - q[i] >= lat && cyc - q[i] <= lat + T_BURST - 1) return 1;
    return 0;
  endfunction
  function automatic logic [NB-1:0] m_vec(input int t);
    logic [NB-1:0] v;
    for (int b = 0; b < NB; b++) v[b] = m_legal(t, b);
    return v;
  endfunction
  function automatic logic [NB-1:0] m_open_vec();
    logic [NB-1:0] v;
    for (int b = 0; b < NB; b++) v[b] = m_open[b];
    return v;
  endfunction

  always @(posedge clk or negedge nRST) begin
    int  t, b;
    bit  ok, known, wrap;
    if (!nRST) m_reset();
    else begin
      t = int'(cmd_type); b = int'(cmd_bank);
      known = cmd_valid && t >= C_ACT && t <= C_REF;
      ok = known && m_legal(t, b);
      m_ill = known && !ok;
      if (ok) begin
        case (t)
          C_ACT: begin m_open[b] = 1; t_act[b] = cyc; t_act_any = cyc; act_q.push_back(cyc); end
          C_RD:  begin t_col = cyc; rd_q.push_back(cyc); end
          C_WR:  begin t_col = cyc; t_wr[b] = cyc; t_wr_any = cyc; wr_q.push_back(cyc); end
          C_PRE: begin m_open[b] = 0; t_pre[b] = cyc; end
          default: t_ref = cyc;
        endcase
      end
      wrap = (cyc % T_REFI) == T_REFI - 1;
      if (wrap && !(ok && t == C_REF)) owed = (owed < MAXP + 1) ? owed + 1 : owed;
      else if (!wrap && ok && t == C_REF) owed = (owed > 0) ? owed - 1 : 0;
      cyc++;
      while (act_q.size() > 0 && cyc - act_q[0] >= T_FAW) void'(act_q.pop_front());
      while (rd_q.size() > 0 && cyc - rd_q[0] > T_RL + T_BURST) void'(rd_q.pop_front());
      while (wr_q.size() > 0 && cyc - wr_q[0] > T_WL + T_BURST) void'(wr_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en && nRST) begin
      chk("act_ok", 32'(act_ok), 32'(m_vec(C_ACT)));
      chk("rd_ok", 32'(rd_ok), 32'(m_vec(C_RD)));
      chk("wr_ok", 32'(wr_ok), 32'(m_vec(C_WR)));
      chk("pre_ok", 32'(pre_ok), 32'(m_vec(C_PRE)));
      chk("ref_ok", 32'(ref_ok), 32'(m_ref_ok()));
      chk("bank_open", 32'(bank_open), 32'(m_open_vec()));
      chk("rd_en", 32'(rd_en), 32'(in_window(rd_q, T_RL)));
      chk("wr_en", 32'(wr_en), 32'(in_window(wr_q, T_WL)));
      chk("rf_req", 32'(rf_req), 32'(owed != 0));
      chk("rf_urgent", 32'(rf_urgent), 32'(owed >= MAXP));
      chk("illegal_cmd", 32'(illegal_cmd), 32'(m_ill));
    end
  end

  task automatic step(input int t, input int b);
    cmd_valid = (t != C_NOP); cmd_type = 3'(t); cmd_bank = 2'(b);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_type = 3'd0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(C_NOP, 0);
  endtask
  task automatic do_reset();
    cmd_valid = 1'b0; nRST = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
  endtask
  task automatic mid_reset(input string tag);
    #2 nRST = 1'b0;
    #1;
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_bank_open"}, 32'(bank_open), 32'd0);
    chk({tag, "_act_ok"}, 32'(act_ok), 32'hF);
    chk({tag, "_illegal"}, 32'(illegal_cmd), 32'd0);
    @(negedge clk);
    nRST = 1'b1;
  endtask

  int lt[$], lb[$];

  initial begin
    do_reset();
    chk_en = 1'b1;
    // Cycle 0: reset values.
    chk("rst_act_ok", 32'(act_ok), 32'hF);
    chk("rst_rd_ok", 32'(rd_ok), 32'd0);
    chk("rst_pre_ok", 32'(pre_ok), 32'd0);
    chk("rst_ref_ok", 32'(ref_ok), 32'd1);
    chk("rst_rf_req", 32'(rf_req), 32'd0);
    step(C_ACT, 0);                                     // cycle 1
    chk("rrd_c1", 32'(act_ok[1]), 32'd0);
    chk("rcd_c1", 32'(rd_ok[0]), 32'd0);
    idle(1); chk("rrd_c2", 32'(act_ok[1]), 32'd1);
    idle(1); chk("rcd_c3", 32'(rd_ok[0]), 32'd0);
    idle(1); chk("rcd_c4", 32'(rd_ok[0]), 32'd1);
    idle(5); chk("ras_c9", 32'(pre_ok[0]), 32'd0);
    idle(1); chk("ras_c10", 32'(pre_ok[0]), 32'd1);

    // Four ACTs, then a re-ACT of bank 0 held off by the four-activate window.
    do_reset();
    step(C_ACT, 0); idle(1); step(C_ACT, 1); idle(1);
    step(C_ACT, 2); idle(1); step(C_ACT, 3); idle(3);   // cycle 10
    step(C_PRE, 0); idle(3);                            // cycle 14
    chk("faw_c14", 32'(act_ok[0]), 32'd0);
    idle(1); chk("faw_c15", 32'(act_ok[0]), 32'd0);
    idle(1); chk("faw_c16", 32'(act_ok[0]), 32'd1);
    step(C_ACT, 0); chk("faw_open", 32'(bank_open), 32'hF);

    // WR at 4, early RD at 8 rejected by write-to-read turnaround.
    do_reset();
    step(C_ACT, 0); idle(3); step(C_WR, 0); idle(2);    // cycle 7
    chk("wr_en_c7", 32'(wr_en), 32'd0);
    idle(1); chk("wr_en_c8", 32'(wr_en), 32'd1);
    chk("wtr_c8", 32'(rd_ok[0]), 32'd0);
    step(C_RD, 0); chk("ill_c9", 32'(illegal_cmd), 32'd1);
    idle(2); chk("wr_en_c11", 32'(wr_en), 32'd1);
    idle(1); chk("wr_en_c12", 32'(wr_en), 32'd0);
    chk("ill_c12", 32'(illegal_cmd), 32'd0);
    idle(2); chk("wtr_c14", 32'(rd_ok[0]), 32'd0);
    idle(1); chk("wtr_c15", 32'(rd_ok[0]), 32'd1);

    // RDs at 4 and 8 give a contiguous read window 9..16, then an aborted window.
    do_reset();
    step(C_ACT, 0); idle(3); step(C_RD, 0); idle(3);    // cycle 8
    chk("rd_en_c8", 32'(rd_en), 32'd0);
    step(C_RD, 0);
    for (int c = 9; c <= 16; c++) begin
      chk("rd_en_burst", 32'(rd_en), 32'd1);
      idle(1);
    end
    chk("rd_en_c17", 32'(rd_en), 32'd0);
    step(C_RD, 0); idle(4);                             // cycle 22
    chk("rd_en_c22", 32'(rd_en), 32'd1);
    mid_reset("arst");

    // REF with a bank open is rejected; a legal REF blocks ACT until tRFC.
    do_reset();
    step(C_ACT, 2); idle(9);                            // cycle 10
    chk("ref_open", 32'(ref_ok), 32'd0);
    step(C_REF, 0);
    chk("ref_ill", 32'(illegal_cmd), 32'd1);
    chk("ref_ill_open", 32'(bank_open), 32'h4);
    step(C_PRE, 2);
    chk("pre_ill", 32'(illegal_cmd), 32'd0);
    idle(2); chk("ref_rp_c14", 32'(ref_ok), 32'd0);
    idle(1); chk("ref_rp_c15", 32'(ref_ok), 32'd1);
    step(C_REF, 0); chk("rfc_c16", 32'(act_ok), 32'd0);
    idle(38); chk("rfc_c54", 32'(act_ok), 32'd0);
    idle(1); chk("rfc_c55", 32'(act_ok), 32'hF);

    // Refresh credit: requests, urgency, and a REF that coincides with a wrap.
    do_reset();
    idle(779); chk("rf_req_c779", 32'(rf_req), 32'd0);
    idle(1); chk("rf_req_c780", 32'(rf_req), 32'd1);
    idle(5459); chk("urg_c6239", 32'(rf_urgent), 32'd0);
    idle(1); chk("urg_c6240", 32'(rf_urgent), 32'd1);
    idle(779);                                          // cycle 7019, a wrap cycle
    step(C_REF, 0); chk("urg_wrapref", 32'(rf_urgent), 32'd1);
    idle(39); chk("ref_ok_c7059", 32'(ref_ok), 32'd1);
    step(C_REF, 0); chk("urg_after_ref", 32'(rf_urgent), 32'd0);

    // Randomized traffic, biased toward currently legal commands.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) mid_reset("rnd_arst");
      if ($urandom_range(0, 99) < 70) begin
        lt.delete(); lb.delete();
        for (int t = C_ACT; t <= C_REF; t++)
          for (int b = 0; b < NB; b++)
            if (m_legal(t, b)) begin lt.push_back(t); lb.push_back(b); end
        if (lt.size() > 0) begin
          int k;
          k = $urandom_range(0, lt.size() - 1);
          step(lt[k], lb[k]);
        end else step(C_NOP, 0);
      end else begin
        step(int'($urandom_range(0, 7)), int'($urandom_range(0, NB - 1)));
      end
    end
    idle(4);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
